// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage divide sequencer and the multi-cycle divider.
// Holds the state encodings, divider handshake levels and the operand magnitude helper.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        DivCtrlIdle,
        DivCtrlBusy,
        DivCtrlDone,
        DivCtrlCancel
    } div_ctrl_state_t;

    typedef enum logic [1:0] {
        DivFree,
        DivByZero,
        DivOn,
        DivEnd
    } div_state_t;

    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;

    // Magnitude of an operand when it is interpreted as signed, otherwise the raw value.
    function automatic logic [31:0] op_mag(input logic is_signed, input logic [31:0] v);
        return (is_signed && v[31]) ? (ZeroWord - v) : v;
    endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle restoring divider: 32 quotient bits, then a sign fix-up step.
// Latency: start seen -> ready 34 cycles later (2 when dividing by zero).
// No backpressure: the result stays presented until start_i drops; annul_i aborts a running divide.
module div
    import div_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_t  state;
    logic [5:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dsr;
    logic [32:0] rem_sh;
    logic [32:0] rem_sub;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        rem_sh  = {rem, quo[31]};
        rem_sub = rem_sh - {1'b0, dsr};
        // Signs come from the live operands, which the sequencer holds for the whole divide.
        quo_fix = (signed_div_i && (opdata1_i[31] ^ opdata2_i[31])) ? (ZeroWord - quo) : quo;
        rem_fix = (signed_div_i && opdata1_i[31]) ? (ZeroWord - rem) : rem;
    end

    assign ready_o = (state == DivEnd) ? DivResultReady : DivResultNotReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            rem      <= ZeroWord;
            quo      <= ZeroWord;
            dsr      <= ZeroWord;
            result_o <= {ZeroWord, ZeroWord};
        end else begin
            unique case (state)
                DivFree: begin
                    if (start_i == DivStart && !annul_i) begin
                        if (opdata2_i == ZeroWord) begin
                            state <= DivByZero;
                        end else begin
                            state <= DivOn;
                            cnt   <= '0;
                            rem   <= ZeroWord;
                            quo   <= op_mag(signed_div_i, opdata1_i);
                            dsr   <= op_mag(signed_div_i, opdata2_i);
                        end
                    end
                end
                DivByZero: begin
                    result_o <= {ZeroWord, ZeroWord};
                    state    <= DivEnd;
                end
                DivOn: begin
                    if (annul_i) begin
                        state <= DivFree;
                    end else if (cnt != 6'd32) begin
                        // A clear borrow bit means the shifted remainder covers the divisor.
                        if (!rem_sub[32]) begin
                            rem <= rem_sub[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= rem_sh[31:0];
                            quo <= {quo[30:0], 1'b0};
                        end
                        cnt <= cnt + 6'd1;
                    end else begin
                        result_o <= {rem_fix, quo_fix};
                        state    <= DivEnd;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) state <= DivFree;
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// EX-stage sequencer for DIV/DIVU: launches the divider, holds operands, writes HI/LO once.
// Latency: request accepted in cycle 0, HI/LO write pulse in cycle 36 (cycle 4 for divide-by-zero).
// Backpressure: stall_o holds the pipeline while busy; a flush annuls the divide and drains the divider.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int CANCEL_CYC = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req_i,
    input  logic        div_signed_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        whilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CW = $clog2(CANCEL_CYC + 1);

    div_ctrl_state_t state;
    div_ctrl_state_t next_state;
    logic [CW-1:0]   cancel_cnt;

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state        <= DivCtrlIdle;
            cancel_cnt   <= '0;
            div_start_o  <= DivStop;
            div_annul_o  <= 1'b0;
            div_signed_o <= 1'b0;
            div_op1_o    <= ZeroWord;
            div_op2_o    <= ZeroWord;
            whilo_we_o   <= 1'b0;
            hi_o         <= ZeroWord;
            lo_o         <= ZeroWord;
        end else begin
            state       <= next_state;
            cancel_cnt  <= (state == DivCtrlCancel && next_state == DivCtrlCancel)
                           ? cancel_cnt + CW'(1) : '0;
            div_start_o <= (next_state == DivCtrlBusy) ? DivStart : DivStop;
            div_annul_o <= (next_state == DivCtrlCancel);
            whilo_we_o  <= (next_state == DivCtrlDone);
            // Operands are captured only on acceptance and stay frozen until the next divide.
            if (state == DivCtrlIdle && next_state == DivCtrlBusy) begin
                div_signed_o <= div_signed_i;
                div_op1_o    <= op1_i;
                div_op2_o    <= op2_i;
            end
            if (state == DivCtrlBusy && next_state == DivCtrlDone) begin
                hi_o <= div_result_i[63:32];
                lo_o <= div_result_i[31:0];
            end
        end
    end

    always_comb begin : next_state_comb
        next_state = state;
        unique case (state)
            DivCtrlIdle:   if (div_req_i && !flush_i) next_state = DivCtrlBusy;
            // Flush wins over a same-cycle ready so a killed divide never writes HI/LO.
            DivCtrlBusy: begin
                if (flush_i)          next_state = DivCtrlCancel;
                else if (div_ready_i) next_state = DivCtrlDone;
            end
            DivCtrlDone:   next_state = DivCtrlIdle;
            DivCtrlCancel: if (cancel_cnt == CW'(CANCEL_CYC - 1)) next_state = DivCtrlIdle;
            default:       next_state = DivCtrlIdle;
        endcase
    end

    always_comb begin : output_comb
        stall_o = (state == DivCtrlBusy)
                | (state == DivCtrlIdle && div_req_i && !flush_i)
                | (state == DivCtrlCancel && div_req_i);
    end

endmodule
